// File: rtl/noun_mem_ctrl.sv
// -----------------------------------------------------------------------------
// noun_mem_ctrl
// Single-requester front end for the noun cell RAM. Accepts read, write and
// cell-allocate requests on a valid/ready channel, drives the RAM port, hides
// the RAM's one-cycle registered read latency and owns the bump-allocation
// free pointer.
//
// Ports
//   clock, reset            : system clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake (one outstanding request)
//   req_op                  : 00 read, 01 write, 10 alloc, 11 reserved
//   req_addr/req_data       : cell address (read/write) and write/alloc data
//   resp_valid/resp_ready   : response handshake
//   resp_data/addr/error    : read data, accessed address, rejection flag
//   free_ptr                : next cell to be allocated (saturates at MEM_DEPTH)
//   mem_address/data/wren   : RAM port, mem_q is the RAM registered read data
// -----------------------------------------------------------------------------
module noun_mem_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 69,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_error,
    output logic [ADDR_W-1:0] free_ptr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ALLOC = 2'b10;

    // Compared one bit wider so MEM_DEPTH == 2**ADDR_W still works.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;

    logic w_addr_ok;
    logic w_alloc_ok;

    assign w_addr_ok  = ({1'b0, req_addr} < DEPTH_X);
    assign w_alloc_ok = ({1'b0, free_ptr} < DEPTH_X);

    // Only combinational output: ready whenever idle and out of reset.
    assign req_ready = (r_state == IDLE) && !reset;

    // Request sequencer: decode, RAM issue, read capture and response hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= 2'b00;
            r_addr      <= '0;
            free_ptr    <= '0;
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            resp_data   <= '0;
            resp_addr   <= '0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op   <= req_op;
                        r_addr <= req_addr;
                        if ((req_op == OP_READ) && w_addr_ok) begin
                            mem_address <= req_addr;
                            mem_wren    <= 1'b0;
                            r_state     <= ISSUE;
                        end else if ((req_op == OP_WRITE) && w_addr_ok) begin
                            mem_address <= req_addr;
                            mem_data    <= req_data;
                            mem_wren    <= 1'b1;
                            r_state     <= ISSUE;
                        end else if ((req_op == OP_ALLOC) && w_alloc_ok) begin
                            mem_address <= free_ptr;
                            mem_data    <= req_data;
                            mem_wren    <= 1'b1;
                            resp_addr   <= free_ptr;
                            r_state     <= ISSUE;
                        end else begin
                            // Rejected: no RAM access; resp_valid rises one
                            // cycle later in RESP so every non-read answers
                            // with the same one-cycle latency.
                            resp_error <= 1'b1;
                            resp_data  <= '0;
                            resp_addr  <= (req_op == OP_ALLOC) ? free_ptr : req_addr;
                            r_state    <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    mem_wren <= 1'b0;
                    if (r_op == OP_READ) begin
                        r_state <= CAPTURE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_data  <= '0;
                        // Alloc was only issued when below MEM_DEPTH, so the
                        // increment saturates the pointer at MEM_DEPTH.
                        if (r_op == OP_ALLOC) begin
                            free_ptr <= free_ptr + ADDR_W'(1);
                        end else begin
                            resp_addr <= r_addr;
                        end
                        r_state <= RESP;
                    end
                end
                CAPTURE: begin
                    resp_data  <= mem_q;
                    resp_addr  <= r_addr;
                    resp_valid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    mem_wren <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
